simd_cs_resolve: RTL

//  Final carry-propagate stage for the SIMD multiply/AND datapath. Accepts a carry-save pair (ps, sc)

---
 rtl/simd_cs_resolve_if.sv | 20 ++
 rtl/simd_cs_resolve.sv | 71 +++++++
 2 files changed

// File: rtl/simd_cs_resolve_if.sv
// simd_cs_resolve_if: carry-save input and resolved-sum output handshake bundle
interface simd_cs_resolve_if #(parameter int WIDTH = 256);
  logic in_valid_i;
  logic in_ready_o;
  logic [WIDTH-1:0] ps_i;
  logic [WIDTH-1:0] sc_i;
  logic [2:0] width_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic [2:0] width_o;
  modport master (
    output in_valid_i, ps_i, sc_i, width_i, out_ready_i,
    input in_ready_o, out_valid_o, sum_o, width_o
  );
  modport slave (
    input in_valid_i, ps_i, sc_i, width_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, width_o
  );
endinterface

// File: rtl/simd_cs_resolve.sv
// simd_cs_resolve: lane-wise carry-save to binary resolver, one CHUNK-bit segment per pipeline stage
module simd_cs_resolve #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 64
) (
  input logic clk_i,
  input logic rst_n_i,
  simd_cs_resolve_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  logic [N:0] r_v;
  logic [WIDTH-1:0] r_a [N+1];
  logic [WIDTH-1:0] r_b [N+1];
  logic [2:0] r_w [N+1];
  logic r_c [N+1];
  logic [WIDTH:0] w_r [N];
  logic [WIDTH-1:0] w_scs;
  logic w_adv;
  function automatic logic is_ls(input int j, input logic [2:0] w);
    return (j % 32 == 0) && (!(|w) || j % 64 == 0) && (!(|w[2:1]) || j % 128 == 0) && (!w[2] || j % 256 == 0);
  endfunction
  // Rank k has segments below k resolved in r_a; higher bits still hold the raw ps/scs pair
  function automatic logic [WIDTH:0] resolve(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] w, input logic cin, input int k);
    logic c;
    resolve = {1'b0, a};
    c = cin;
    for (int j = k * CHUNK; j < (k + 1) * CHUNK; j++) begin
      c = c & !is_ls(j, w);
      resolve[j] = a[j] ^ b[j] ^ c;
      c = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
    end
    resolve[WIDTH] = c;
  endfunction
  assign w_adv = !r_v[N] || bus.out_ready_i;
  always_comb begin
    w_scs = '0;
    for (int j = 1; j < WIDTH; j++) w_scs[j] = bus.sc_i[j-1] & !is_ls(j, bus.width_i);
    for (int k = 0; k < N; k++) w_r[k] = resolve(r_a[k], r_b[k], r_w[k], r_c[k], k);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_v <= '0;
      for (int k = 0; k <= N; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_w[k] <= '0;
        r_c[k] <= 1'b0;
      end
    end else if (w_adv) begin
      r_v <= {r_v[N-1:0], bus.in_valid_i};
      if (bus.in_valid_i) begin
        r_a[0] <= bus.ps_i;
        r_b[0] <= w_scs;
        r_w[0] <= bus.width_i;
      end
      for (int k = 0; k < N; k++) begin
        if (r_v[k]) begin
          r_a[k+1] <= w_r[k][WIDTH-1:0];
          r_b[k+1] <= r_b[k];
          r_w[k+1] <= r_w[k];
          r_c[k+1] <= w_r[k][WIDTH];
        end
      end
    end
  end
  assign bus.in_ready_o = w_adv;
  assign bus.out_valid_o = r_v[N];
  assign bus.sum_o = r_a[N];
  assign bus.width_o = r_w[N];
endmodule
